// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one bit per cycle, 34-cycle start-to-done latency.
// Operands are latched as magnitudes at accept and the sign is restored in a single fix-up cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            we
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   function automatic logic [XLEN-1:0] cond_neg_w(input logic [XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_dw(input logic [2*XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op_q;
   logic [4:0]          rd_q;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     mcand;
   logic                neg_q;
   logic                rem_neg_q;
   logic                div0_q;

   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   is_div;
   logic                   a_signed;
   logic                   b_signed;
   logic                   a_neg;
   logic                   b_neg;
   logic [XLEN-1:0]        abs_a;
   logic [XLEN-1:0]        abs_b;

   logic [XLEN:0]          mul_sum;
   logic [2*XLEN-1:0]      mul_next;
   logic [XLEN:0]          div_tmp;
   logic [XLEN-1:0]        div_diff;
   logic                   div_ge;
   logic [2*XLEN-1:0]      div_next;

   logic [2*XLEN-1:0]      prod_fix;
   logic [XLEN-1:0]        quo_fix;
   logic [XLEN-1:0]        rem_fix;
   logic [XLEN-1:0]        fix_val;

   // Accept stage: operand magnitudes and result signs
   always_comb begin
      rs1_s    = signed'(rs1_val);
      rs2_s    = signed'(rs2_val);
      is_div   = funct3[2];
      a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
      b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
      a_neg    = a_signed && (rs1_s < 0);
      b_neg    = b_signed && (rs2_s < 0);
      abs_a    = cond_neg_w(rs1_val, a_neg);
      abs_b    = cond_neg_w(rs2_val, b_neg);
   end

   // Iteration stage: prod holds {acc, multiplier} for multiply and {remainder, quotient} for divide
   always_comb begin
      mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
      mul_next = {mul_sum, prod[XLEN-1:1]};
      div_tmp  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      div_ge   = div_tmp >= {1'b0, mcand};
      div_diff = div_tmp[XLEN-1:0] - mcand;
      div_next = div_ge ? {div_diff, prod[XLEN-2:0], 1'b1}
                        : {div_tmp[XLEN-1:0], prod[XLEN-2:0], 1'b0};
   end

   // Fix-up stage: sign restore and word select
   always_comb begin
      prod_fix = cond_neg_dw(prod, neg_q);
      quo_fix  = div0_q ? '1 : cond_neg_w(prod[XLEN-1:0], neg_q);
      rem_fix  = cond_neg_w(prod[2*XLEN-1:XLEN], rem_neg_q);
      case (op_q)
         F_MUL:                     fix_val = prod_fix[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             fix_val = quo_fix;
         default:                   fix_val = rem_fix;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         prod      <= '0;
         mcand     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         we        <= 1'b0;
         result    <= '0;
         rd_out    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               we   <= 1'b0;
               if (start) begin
                  op_q      <= funct3;
                  rd_q      <= rd_in;
                  cnt       <= '0;
                  prod      <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                  mcand     <= is_div ? abs_b : abs_a;
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  div0_q    <= is_div && (rs2_val == '0);
                  busy      <= 1'b1;
                  state     <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               prod <= op_q[2] ? div_next : mul_next;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(XLEN - 1))
                  state <= FIX;
            end
            FIX: begin
               result <= fix_val;
               rd_out <= rd_q;
               done   <= 1'b1;
               we     <= (rd_q != 5'd0);
               busy   <= 1'b0;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
